// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory access arbiter.
// Holds the FSM state encoding used by mem_access_arbiter.
package mem_arb_pkg;

    localparam int DEF_NREQ = 2;
    localparam int DEF_AW   = 4;
    localparam int DEF_DW   = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: scans requests starting just after the last
// grant and returns the first one found as one-hot and as an index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx
);

    logic          w_found;
    int            w_pos;
    logic [IW-1:0] w_sel;

    // Rotating priority scan, first hit after i_last wins
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_pos    = 0;
        w_sel    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_pos = int'(i_last) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            w_sel = IW'(w_pos);
            if (!w_found && i_req[w_sel]) begin
                w_found         = 1'b1;
                o_onehot[w_sel] = 1'b1;
                o_idx           = w_sel;
            end
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Multi-requester single-port memory arbiter, round-robin, one access
// at a time. Define MEM_ARB_RD_CHECK_EN to flag reads of unwritten words.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         we,
    input  logic [NREQ*AW-1:0]      addr,
    input  logic [NREQ*DW-1:0]      wdata,
    output logic [NREQ-1:0]         gnt,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [DW-1:0]           rsp_data,
    output logic                    rsp_err,
    output logic                    mem_write,
    output logic                    mem_read,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      r_state;
    arb_state_t      w_state_nx;

    logic [IW-1:0]   r_last;
    logic [IW-1:0]   r_id;
    logic [NREQ-1:0] r_gnt;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;

    logic            r_rsp_valid;
    logic [IW-1:0]   r_rsp_id;
    logic [DW-1:0]   r_rsp_data;

    logic [NREQ-1:0] w_onehot;
    logic [IW-1:0]   w_idx;
    logic            w_take;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .i_req    (req),
        .i_last   (r_last),
        .o_onehot (w_onehot),
        .o_idx    (w_idx)
    );

    assign w_take = (r_state == ST_IDLE) && (|req);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state and per-state strobes; only ACCESS talks to memory
    always_comb begin
        w_state_nx = r_state;
        gnt        = '0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                gnt        = r_gnt;
                mem_write  = r_we;
                mem_read   = !r_we;
                w_state_nx = r_we ? ST_IDLE : ST_RDWAIT;
            end
            ST_RDWAIT: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Latch the winner's command; remember who was served last
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last  <= IW'(NREQ - 1);
            r_id    <= '0;
            r_gnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_take) begin
                r_id    <= w_idx;
                r_gnt   <= w_onehot;
                r_we    <= we[w_idx];
                r_addr  <= addr[w_idx*AW +: AW];
                r_wdata <= wdata[w_idx*DW +: DW];
            end
            if (r_state == ST_ACCESS) begin
                r_last <= r_id;
            end
        end
    end

    // Capture read data at the end of RDWAIT; data holds between pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= (r_state == ST_RDWAIT);
            if (r_state == ST_RDWAIT) begin
                r_rsp_id   <= r_id;
                r_rsp_data <= mem_rdata;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

`ifdef MEM_ARB_RD_CHECK_EN

    logic [2**AW-1:0] r_written;
    logic             r_rsp_err;

    // Track which words have ever been written since reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_written <= '0;
        end else if ((r_state == ST_ACCESS) && r_we) begin
            r_written[r_addr] <= 1'b1;
        end
    end

    // Error flag travels alongside the read response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_err <= 1'b0;
        end else if (r_state == ST_RDWAIT) begin
            r_rsp_err <= !r_written[r_addr];
        end
    end

    assign rsp_err = r_rsp_err;

`else

    assign rsp_err = 1'b0;

`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter (NREQ=2, AW=4, DW=32) with a
// one-cycle-latency memory model attached to the memory port.
module tb_mem_access_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [1:0]  gnt;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_write;
    logic        mem_read;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [16];

    int errors;
    int checks;

`ifdef MEM_ARB_RD_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    mem_access_arbiter #(
        .NREQ (2),
        .AW   (4),
        .DW   (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 + i;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({gnt, rsp_valid, rsp_err, mem_read, mem_write} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b exp 000000",
                     {gnt, rsp_valid, rsp_err, mem_read, mem_write});
        end
        checks++;
        if ({rsp_id, rsp_data} !== 33'b0) begin
            errors++;
            $display("FAIL reset_rsp: got id=%0d data=%h exp 0", rsp_id, rsp_data);
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 36'b0) begin
            errors++;
            $display("FAIL reset_mem: got a=%h d=%h exp 0", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_write;
        req = 2'b01;
        we = 2'b01;
        addr[3:0] = 4'd1;
        wdata[31:0] = 32'h1234_5678;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL wr_gnt: got %b exp 01", gnt);
        end
        checks++;
        if ({mem_write, mem_read} !== 2'b10) begin
            errors++;
            $display("FAIL wr_strobe: got w=%b r=%b exp w=1 r=0", mem_write, mem_read);
        end
        checks++;
        if (mem_addr !== 4'd1 || mem_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL wr_bus: got a=%h d=%h exp a=1 d=12345678", mem_addr, mem_wdata);
        end
        req = '0;
        tick();
        checks++;
        if ({gnt, mem_write, mem_read} !== 4'b0) begin
            errors++;
            $display("FAIL wr_idle: got %b exp 0000", {gnt, mem_write, mem_read});
        end
    endtask

    task automatic test_read;
        req = 2'b10;
        we = 2'b00;
        addr[7:4] = 4'd1;
        tick();
        checks++;
        if (gnt !== 2'b10 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rd_access: got gnt=%b r=%b w=%b exp 10 1 0", gnt, mem_read, mem_write);
        end
        req = '0;
        tick();
        checks++;
        if ({gnt, mem_read, mem_write, rsp_valid} !== 5'b0) begin
            errors++;
            $display("FAIL rd_wait: got %b exp 00000", {gnt, mem_read, mem_write, rsp_valid});
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL rd_rsp: got v=%b id=%0d exp v=1 id=1", rsp_valid, rsp_id);
        end
        checks++;
        if (rsp_data !== 32'h1234_5678 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_data: got %h err=%b exp 12345678 err=0", rsp_data, rsp_err);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL rd_hold: got v=%b d=%h exp v=0 d=12345678", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_seq [4];
        int n;
        exp_seq[0] = 2'b01;
        exp_seq[1] = 2'b10;
        exp_seq[2] = 2'b01;
        exp_seq[3] = 2'b10;
        n = 0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (gnt !== 2'b00) begin
                errors++;
                $display("FAIL idle_gnt: got %b exp 00 at cycle %0d", gnt, c);
            end
        end
        req = 2'b11;
        we = 2'b11;
        addr = {4'd3, 4'd2};
        wdata = {32'hBBBB_0003, 32'hAAAA_0002};
        for (int c = 0; c < 20 && n < 4; c++) begin
            tick();
            if (gnt !== 2'b00) begin
                checks++;
                if (gnt !== exp_seq[n]) begin
                    errors++;
                    $display("FAIL b2b_gnt%0d: got %b exp %b", n, gnt, exp_seq[n]);
                end
                n++;
            end
        end
        req = '0;
        tick();
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d grants exp 4", n);
        end
    endtask

    task automatic test_rd_err;
        do_reset();
        req = 2'b01;
        we = 2'b00;
        addr = 8'h00;
        tick();
        req = '0;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== EXP_ERR) begin
            errors++;
            $display("FAIL rderr_unwritten: got v=%b err=%b exp v=1 err=%b",
                     rsp_valid, rsp_err, EXP_ERR);
        end
        req = 2'b01;
        we = 2'b01;
        wdata[31:0] = 32'h0000_00AA;
        tick();
        req = '0;
        tick();
        req = 2'b01;
        we = 2'b00;
        tick();
        req = '0;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h0000_00AA) begin
            errors++;
            $display("FAIL rderr_written: got v=%b err=%b d=%h exp 1 0 000000aa",
                     rsp_valid, rsp_err, rsp_data);
        end
    endtask

    task automatic test_reset_mid_read;
        req = 2'b01;
        we = 2'b00;
        addr[3:0] = 4'd1;
        tick();
        req = '0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rsp_valid, rsp_err, mem_read, mem_write, rsp_id} !== 7'b0) begin
            errors++;
            $display("FAIL midrst_ctl: got %b exp 0",
                     {gnt, rsp_valid, rsp_err, mem_read, mem_write, rsp_id});
        end
        checks++;
        if ({rsp_data, mem_addr, mem_wdata} !== 68'b0) begin
            errors++;
            $display("FAIL midrst_data: got d=%h a=%h w=%h exp 0", rsp_data, mem_addr, mem_wdata);
        end
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_norsp: got v=%b exp 0 at cycle %0d", rsp_valid, c);
            end
        end
        req = 2'b11;
        we = 2'b11;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL midrst_next: got %b exp 01", gnt);
        end
        req = '0;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_rd_err();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter AW, default 4, memory address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  NREQ  per-requester access request, held until granted.
REQ-007 SHALL have port we  input  NREQ  per-requester 1=write, 0=read.
REQ-008 SHALL have port addr  input  NREQ*AW  per-requester address, packed, requester i at [i*AW +: AW].
REQ-009 SHALL have port wdata  input  NREQ*DW  per-requester write data, packed likewise.
REQ-010 SHALL have port gnt  output  NREQ  one-hot grant pulse, one cycle.
REQ-011 SHALL have port rsp_valid  output  1  read-response pulse, one cycle.
REQ-012 SHALL have port rsp_id  output  $clog2(NREQ)  index of the requester owning the response.
REQ-013 SHALL have port rsp_data  output  DW  read data, valid with rsp_valid.
REQ-014 SHALL have port rsp_err  output  1  read of a never-written address, valid with rsp_valid.
REQ-015 SHALL have memory-side ports mem_write, mem_read (1), mem_addr (AW), mem_wdata (DW) as outputs and mem_rdata (DW) as input; the memory returns mem_rdata one cycle after mem_read.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> (write: IDLE | read: RDWAIT -> IDLE).
REQ-017 In IDLE with any req bit set, SHALL pick a winner round-robin, starting from (last_grant+1) mod NREQ, and latch its we/addr/wdata.
REQ-018 SHALL, in the ACCESS cycle, drive gnt[winner]=1 and exactly one of mem_write/mem_read, with mem_addr and mem_wdata taken from the latched values.
REQ-019 SHALL drive mem_read, mem_write and gnt to 0 in every state other than ACCESS.
REQ-020 SHALL register mem_rdata in RDWAIT and assert rsp_valid, rsp_id and rsp_data in the following cycle. Read latency from the IDLE cycle in which req is sampled to rsp_valid is 3 cycles.
REQ-021 SHALL update last_grant only on a grant; if no req is set, it stays IDLE with last_grant unchanged.
REQ-022 SHALL, when multiple requests are present simultaneously, grant exactly one; the others wait, and no requester waits more than NREQ-1 grants.
REQ-023 SHALL ignore a req deasserted before its grant; the requester must drop req in the cycle after gnt.
REQ-024 SHALL hold rsp_data at its last value when rsp_valid=0.

Reset
REQ-025 On reset_n low, SHALL enter IDLE asynchronously, with gnt=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_data=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0 and last_grant=NREQ-1 (so requester 0 wins first).
REQ-026 SHALL drop any in-flight read on reset mid-operation, without a subsequent rsp_valid.

Configuration
REQ-027 With MEM_ARB_RD_CHECK_EN defined, SHALL keep a 2**AW-bit written-flag array, cleared by reset and set on each mem_write. A read of an unflagged address still executes and returns rsp_err=1.
REQ-028 Without MEM_ARB_RD_CHECK_EN, SHALL omit the array and tie rsp_err to 0; the ports are unchanged.

Structure
REQ-029 SHALL place the FSM state enum and the default parameter constants in package mem_arb_pkg.
REQ-030 SHALL implement round-robin selection in sub-module rr_arbiter (inputs: req vector, last_grant; outputs: one-hot and index).

Verification
REQ-031 Reset, then requester 0 writes addr=1, wdata=0x12345678 -> gnt=01 one cycle later with mem_write=1, mem_addr=1.
REQ-032 Requester 1 reads addr=1 after REQ-031 -> rsp_valid 3 cycles after req sampled, rsp_id=1, rsp_data=0x12345678, rsp_err=0.
REQ-033 Both requesters request continuously -> grants alternate 01,10,01,10.
REQ-034 MEM_ARB_RD_CHECK_EN defined, read of addr=0 after reset -> rsp_valid=1, rsp_err=1; without the macro, rsp_err=0.
REQ-035 reset_n pulsed low during RDWAIT -> no rsp_valid, all outputs 0, the next grant goes to requester 0.
